// File: rtl/mxv_rx_loader_if.sv
// mxv_rx_loader_if
//   UART receive-side handshake between a UART receiver and mxv_rx_loader.
//   Handshake: the UART raises RxInterrupt with ReceivedData stable and keeps
//   both steady until it sees ClearInterrupt. The loader takes the byte on the
//   first cycle where RxInterrupt=1 and ClearInterrupt=0, then pulses
//   ClearInterrupt for exactly one cycle. RxInterrupt is ignored during that
//   pulse, so a level flag that has not yet dropped is never taken twice.
//   Signals:
//     RxInterrupt     UART -> loader  byte-ready flag
//     ReceivedData    UART -> loader  received byte
//     ClearInterrupt  loader -> UART  one-cycle acknowledge
//     dbg_state       loader -> any   current parser state, for observation
interface mxv_rx_loader_if #(
   parameter int WORD_LENGTH = 8
) ();
   logic                   RxInterrupt;
   logic [WORD_LENGTH-1:0] ReceivedData;
   logic                   ClearInterrupt;
   logic [2:0]             dbg_state;

   modport master (
      output RxInterrupt,
      output ReceivedData,
      input  ClearInterrupt,
      input  dbg_state
   );

   modport slave (
      input  RxInterrupt,
      input  ReceivedData,
      output ClearInterrupt,
      output dbg_state
   );
endinterface

// File: rtl/mxv_rx_loader.sv
// mxv_rx_loader
//   Parses framed commands arriving byte by byte from a UART and loads the
//   MxV engine: matrix dimension, input vector, matrix elements (streamed to
//   a FIFO) and a start pulse.
//   Frame: 0xFE, LEN, CMD, payload[LEN-1], 0xEF  (LEN counts CMD + payload)
//     0x01 set size    LEN=2      payload N (1..8)
//     0x02 start       LEN=1
//     0x03 load vector LEN=1+N    bytes land in a shadow, committed on tail
//     0x04 load matrix LEN=1+N*N  bytes forwarded to the FIFO as they arrive
//   Ports:
//     clk, reset     clock, synchronous active-low reset
//     rx             UART handshake (slave side of mxv_rx_loader_if)
//     Matrix_length  committed dimension N
//     vector         committed vector, element i in bits [8i+7:8i]
//     FIFOvalue      matrix element, qualified by FIFOpush
//     FIFOpush       one-cycle push strobe
//     start          one-cycle start pulse
//     frame_error    one-cycle pulse when a frame is rejected
module mxv_rx_loader #(
   parameter int WORD_LENGTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   mxv_rx_loader_if.slave         rx,
   output logic [31:0]            Matrix_length,
   output logic [63:0]            vector,
   output logic [WORD_LENGTH-1:0] FIFOvalue,
   output logic                   FIFOpush,
   output logic                   start,
   output logic                   frame_error
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] GET_LEN  = 3'd1;
   localparam logic [2:0] GET_CMD  = 3'd2;
   localparam logic [2:0] GET_DATA = 3'd3;
   localparam logic [2:0] GET_TAIL = 3'd4;
   localparam logic [2:0] EXEC     = 3'd5;

   localparam logic [7:0] SOF = 8'hFE;
   localparam logic [7:0] EOF = 8'hEF;

   logic [2:0]  state_q,  state_d;
   logic [7:0]  len_q,    len_d;
   logic [7:0]  cmd_q,    cmd_d;
   logic [6:0]  cnt_q,    cnt_d;
   logic [7:0]  n_q,      n_d;
   logic [63:0] shadow_q, shadow_d;
   logic [31:0] mlen_q,   mlen_d;
   logic [63:0] vec_q,    vec_d;
   logic [7:0]  fifo_q,   fifo_d;
   logic        push_q,   push_d;
   logic        start_q,  start_d;
   logic        ferr_q,   ferr_d;
   logic        clr_q;

   logic [7:0]  rx_byte;
   logic        accept;
   logic [7:0]  n8;
   logic [7:0]  exp_len;
   logic        cmd_ok;
   logic [7:0]  cnt_next;

   assign rx_byte = rx.ReceivedData;
   assign accept  = rx.RxInterrupt && !clr_q;
   assign n8      = mlen_q[7:0];
   assign cnt_next = {1'b0, cnt_q} + 8'd1;

   // Required LEN for the command byte currently on the bus; N is at most 8,
   // so N*N fits in eight bits.
   always_comb begin
      exp_len = 8'd0;
      cmd_ok  = 1'b1;
      case (rx_byte)
         8'h01:   exp_len = 8'd2;
         8'h02:   exp_len = 8'd1;
         8'h03:   exp_len = 8'd1 + n8;
         8'h04:   exp_len = 8'd1 + n8 * n8;
         default: cmd_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cmd_d    = cmd_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      shadow_d = shadow_q;
      mlen_d   = mlen_q;
      vec_d    = vec_q;
      fifo_d   = fifo_q;
      push_d   = 1'b0;
      start_d  = 1'b0;
      ferr_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // Anything other than a start-of-frame byte is line noise.
            if (accept && rx_byte == SOF) state_d = GET_LEN;
         end
         GET_LEN: begin
            if (accept) begin
               len_d   = rx_byte;
               state_d = GET_CMD;
            end
         end
         GET_CMD: begin
            if (accept) begin
               cmd_d    = rx_byte;
               cnt_d    = 7'd0;
               shadow_d = 64'd0;
               if (!cmd_ok || len_q == 8'd0 || len_q != exp_len) begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end else if (len_q == 8'd1) begin
                  state_d = GET_TAIL;
               end else begin
                  state_d = GET_DATA;
               end
            end
         end
         GET_DATA: begin
            if (accept) begin
               case (cmd_q)
                  8'h01: n_d = rx_byte;
                  // cnt_q < N <= 8 here, so the low three bits select the lane.
                  8'h03: shadow_d[{cnt_q[2:0], 3'b000} +: 8] = rx_byte;
                  8'h04: begin
                     fifo_d = rx_byte;
                     push_d = 1'b1;
                  end
                  default: ;
               endcase
               cnt_d = cnt_q + 7'd1;
               if (cnt_next == len_q - 8'd1) state_d = GET_TAIL;
            end
         end
         GET_TAIL: begin
            if (accept) begin
               if (rx_byte == EOF) begin
                  state_d = EXEC;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         EXEC: begin
            case (cmd_q)
               8'h01: begin
                  if (n_q == 8'd0 || n_q > 8'd8) ferr_d = 1'b1;
                  else                           mlen_d = {24'd0, n_q};
               end
               8'h02:   start_d = 1'b1;
               8'h03:   vec_d   = shadow_q;
               default: ;
            endcase
            cnt_d   = 7'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         len_q    <= 8'd0;
         cmd_q    <= 8'd0;
         cnt_q    <= 7'd0;
         n_q      <= 8'd0;
         shadow_q <= 64'd0;
         mlen_q   <= 32'd8;
         vec_q    <= 64'd0;
         fifo_q   <= 8'd0;
         push_q   <= 1'b0;
         start_q  <= 1'b0;
         ferr_q   <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cmd_q    <= cmd_d;
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         shadow_q <= shadow_d;
         mlen_q   <= mlen_d;
         vec_q    <= vec_d;
         fifo_q   <= fifo_d;
         push_q   <= push_d;
         start_q  <= start_d;
         ferr_q   <= ferr_d;
         clr_q    <= accept;
      end
   end

   assign rx.ClearInterrupt = clr_q;
   assign rx.dbg_state      = state_q;
   assign Matrix_length     = mlen_q;
   assign vector            = vec_q;
   assign FIFOvalue         = fifo_q;
   assign FIFOpush          = push_q;
   assign start             = start_q;
   assign frame_error       = ferr_q;

endmodule

// File: tb/tb_mxv_rx_loader.sv
module tb_mxv_rx_loader;

   typedef logic [7:0] byte_q_t[$];

   logic        clk;
   logic        reset;
   logic [31:0] Matrix_length;
   logic [63:0] vector;
   logic [7:0]  FIFOvalue;
   logic        FIFOpush;
   logic        start;
   logic        frame_error;

   int checks;
   int errors;

   int push_cnt;
   int start_cnt;
   int ferr_cnt;
   int clr_cnt;
   int dbl_cnt;
   logic prev_push, prev_start, prev_ferr, prev_clr;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   mxv_rx_loader_if #(.WORD_LENGTH(8)) uart ();

   mxv_rx_loader #(.WORD_LENGTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx            (uart.slave),
      .Matrix_length (Matrix_length),
      .vector        (vector),
      .FIFOvalue     (FIFOvalue),
      .FIFOpush      (FIFOpush),
      .start         (start),
      .frame_error   (frame_error)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pulse monitor, sampled mid-cycle
   initial begin
      push_cnt = 0; start_cnt = 0; ferr_cnt = 0; clr_cnt = 0; dbl_cnt = 0;
      prev_push = 0; prev_start = 0; prev_ferr = 0; prev_clr = 0;
   end
   always @(negedge clk) begin
      if (FIFOpush) begin
         push_cnt++;
         got_q.push_back(FIFOvalue);
      end
      if (start)               start_cnt++;
      if (frame_error)         ferr_cnt++;
      if (uart.ClearInterrupt) clr_cnt++;
      if ((FIFOpush && prev_push) || (start && prev_start) ||
          (frame_error && prev_ferr) || (uart.ClearInterrupt && prev_clr))
         dbl_cnt++;
      prev_push  = FIFOpush;
      prev_start = start;
      prev_ferr  = frame_error;
      prev_clr   = uart.ClearInterrupt;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one byte and hold it until acknowledged; returns #1 after the
   // accepting edge's follow-up, i.e. while ClearInterrupt is high.
   task automatic send_byte(input logic [7:0] b);
      bit done;
      done = 0;
      @(negedge clk);
      uart.RxInterrupt  = 1'b1;
      uart.ReceivedData = b;
      for (int i = 0; i < 10 && !done; i++) begin
         @(posedge clk);
         #1;
         if (uart.ClearInterrupt) done = 1;
      end
      uart.RxInterrupt = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL ack_timeout: observed no ClearInterrupt expected ack for byte %0h", b);
      end
   endtask

   task automatic send_seq(input byte_q_t s);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compare everything pushed so far against the expected queue.
   task automatic drain_scoreboard(input string tag);
      logic [7:0] e, g;
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         check({tag, "_data"}, 64'(g), 64'(e));
      end
      exp_q.delete();
      got_q.delete();
   endtask

   int b_push, b_start, b_ferr, b_clr;
   task automatic snap();
      b_push = push_cnt; b_start = start_cnt; b_ferr = ferr_cnt; b_clr = clr_cnt;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      uart.RxInterrupt  = 1'b0;
      uart.ReceivedData = 8'h00;

      // reset state
      cycles(3);
      check("rst_mlen",   64'(Matrix_length), 64'd8);
      check("rst_vector", vector, 64'd0);
      check("rst_fifo",   64'(FIFOvalue), 64'd0);
      check("rst_pulses", {60'd0, FIFOpush, start, frame_error, uart.ClearInterrupt}, 64'd0);
      check("rst_state",  64'(uart.dbg_state), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      cycles(2);

      // set size N=4
      snap();
      send_seq('{8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF});
      check("size_before_exec", 64'(Matrix_length), 64'd8);
      cycles(1);
      check("size_commit", 64'(Matrix_length), 64'd4);
      cycles(2);
      check("size_clr_pulses", 64'(clr_cnt - b_clr), 64'd5);
      check("size_no_ferr",    64'(ferr_cnt - b_ferr), 64'd0);

      // load vector with N=4
      send_seq('{8'hFE, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF});
      check("vec_before_exec", vector, 64'd0);
      cycles(1);
      check("vec_commit", vector, 64'h0000_0000_4433_2211);

      // N=2 then matrix stream
      send_seq('{8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF});
      cycles(1);
      check("size2_commit", 64'(Matrix_length), 64'd2);
      snap();
      exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
      exp_q.push_back(8'h0C); exp_q.push_back(8'h0D);
      send_seq('{8'hFE, 8'h05, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEF});
      cycles(3);
      drain_scoreboard("mat");
      check("mat_push_count", 64'(push_cnt - b_push), 64'd4);
      check("mat_no_start",   64'(start_cnt - b_start), 64'd0);
      check("mat_no_ferr",    64'(ferr_cnt - b_ferr), 64'd0);

      // start command, plain and with leading noise
      snap();
      send_seq('{8'hFE, 8'h01, 8'h02, 8'hEF});
      cycles(3);
      check("start_once", 64'(start_cnt - b_start), 64'd1);
      snap();
      send_seq('{8'h55, 8'hFE, 8'h01, 8'h02, 8'hEF});
      cycles(3);
      check("start_noise_once", 64'(start_cnt - b_start), 64'd1);
      check("start_noise_ferr", 64'(ferr_cnt - b_ferr), 64'd0);

      // matrix with bad tail: pushes stand, error pulses
      snap();
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h03); exp_q.push_back(8'h04);
      send_seq('{8'hFE, 8'h05, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00});
      cycles(3);
      drain_scoreboard("matbad");
      check("matbad_ferr", 64'(ferr_cnt - b_ferr), 64'd1);

      // short vector with N=2: upper elements cleared
      send_seq('{8'hFE, 8'h03, 8'h03, 8'hAA, 8'hBB, 8'hEF});
      cycles(1);
      check("vec2_commit", vector, 64'h0000_0000_0000_BBAA);

      // back to N=4, vector frame with bad tail
      send_seq('{8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF});
      cycles(1);
      snap();
      send_seq('{8'hFE, 8'h05, 8'h03, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00});
      cycles(3);
      check("vecbad_ferr",   64'(ferr_cnt - b_ferr), 64'd1);
      check("vecbad_retain", vector, 64'h0000_0000_0000_BBAA);
      send_seq('{8'hFE, 8'h05, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF});
      cycles(1);
      check("vec_after_bad", vector, 64'h0000_0000_0403_0201);

      // LEN mismatch, unknown command, LEN=0
      snap();
      send_seq('{8'hFE, 8'h03, 8'h01});
      cycles(2);
      check("lenmis_ferr", 64'(ferr_cnt - b_ferr), 64'd1);
      check("lenmis_idle", 64'(uart.dbg_state), 64'd0);
      snap();
      send_seq('{8'hFE, 8'h01, 8'h07});
      cycles(2);
      check("badcmd_ferr", 64'(ferr_cnt - b_ferr), 64'd1);
      snap();
      send_seq('{8'hFE, 8'h00, 8'h02});
      cycles(2);
      check("len0_ferr", 64'(ferr_cnt - b_ferr), 64'd1);

      // illegal sizes rejected in EXEC
      snap();
      send_seq('{8'hFE, 8'h02, 8'h01, 8'h00, 8'hEF});
      cycles(2);
      send_seq('{8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF});
      cycles(2);
      check("badsize_ferr", 64'(ferr_cnt - b_ferr), 64'd2);
      check("badsize_keep", 64'(Matrix_length), 64'd4);

      // reset mid-frame
      snap();
      send_seq('{8'hFE, 8'h05, 8'h03, 8'h11});
      @(negedge clk);
      reset = 1'b0;
      cycles(1);
      check("mid_rst_mlen",  64'(Matrix_length), 64'd8);
      check("mid_rst_vec",   vector, 64'd0);
      check("mid_rst_fifo",  64'(FIFOvalue), 64'd0);
      check("mid_rst_state", 64'(uart.dbg_state), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      cycles(1);
      send_seq('{8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF});
      cycles(2);
      check("post_rst_size", 64'(Matrix_length), 64'd3);
      check("post_rst_ferr", 64'(ferr_cnt - b_ferr), 64'd0);

      check("no_double_pulse", 64'(dbl_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
